// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared sizing helpers and default flag offsets.
// Optional error flags are enabled with `define SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

  localparam int AF_OFFSET = 2;
  localparam int AE_DEFAULT = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo storage: DEPTH x DATA_W array with registered read.
// Array is never reset; only the read register clears on rst.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 90
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap pointers, occupancy count, level flags.
// Sticky overflow/underflow exist only with `define SYNC_FIFO_ERR_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 90,
  parameter int AF_LVL = DEPTH - AF_OFFSET,
  parameter int AE_LVL = AE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // Non power-of-2 depth: wrap explicitly at DEPTH-1.
  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !full && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= inc(rd_ptr);
      end
      unique case (1'b1)
        (wr_acc && !rd_acc): count <= count + 1'b1;
        (rd_acc && !wr_acc): count <= count - 1'b1;
        default:             count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH 90, DATA_W 8).
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [6:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad = 0;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (90)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (count !== 7'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1010",
               {empty, full, almost_empty, almost_full});
    end
    total++;
    if ({rd_valid, rd_data} !== 9'd0) begin
      bad++;
      $display("FAIL reset_rd got=%b/%h want=0/00", rd_valid, rd_data);
    end
    total++;
    if ({overflow, underflow} !== 2'b00) begin
      bad++;
      $display("FAIL reset_err got=%b want=00", {overflow, underflow});
    end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      total++;
      if (count !== 7'(i + 1)) begin
        bad++;
        $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1);
      end
      total++;
      if (almost_full !== (i + 1 >= 88)) begin
        bad++;
        $display("FAIL fill_af i=%0d got=%b", i, almost_full);
      end
      total++;
      if (full !== (i + 1 == 90)) begin
        bad++;
        $display("FAIL fill_full i=%0d got=%b", i, full);
      end
    end
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    total++;
    if (count !== 7'd90 || full !== 1'b1) begin
      bad++;
      $display("FAIL fill_extra got=%0d/%b want=90/1", count, full);
    end
    total++;
    if (overflow !== ERR) begin
      bad++;
      $display("FAIL fill_ovf got=%b want=%b", overflow, ERR);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 90; i++) begin
      rd_en = 1'b1;
      tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        bad++;
        $display("FAIL drain_data i=%0d got=%b/%h want=1/%h",
                 i, rd_valid, rd_data, 8'(i));
      end
      total++;
      if (count !== 7'(89 - i)) begin
        bad++;
        $display("FAIL drain_count i=%0d got=%0d", i, count);
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty got=%b want=1", empty);
    end
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h59) begin
      bad++;
      $display("FAIL drain_extra got=%b/%h want=0/59", rd_valid, rd_data);
    end
    total++;
    if (underflow !== ERR || overflow !== ERR) begin
      bad++;
      $display("FAIL drain_err got=%b%b want=%b%b",
               overflow, underflow, ERR, ERR);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 60; i++) begin
        wr_en = 1'b1;
        wr_data = 8'((i * 3 + 7 + r * 50) & 8'hFF);
        tick();
        total++;
        if (full !== 1'b0) begin
          bad++;
          $display("FAIL wrap_full r=%0d i=%0d got=1 want=0", r, i);
        end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 60; i++) begin
        rd_en = 1'b1;
        tick();
        total++;
        if (rd_data !== 8'((i * 3 + 7 + r * 50) & 8'hFF)) begin
          bad++;
          $display("FAIL wrap_data r=%0d i=%0d got=%h want=%h",
                   r, i, rd_data, 8'((i * 3 + 7 + r * 50) & 8'hFF));
        end
      end
      rd_en = 1'b0;
      total++;
      if (empty !== 1'b1) begin
        bad++;
        $display("FAIL wrap_empty r=%0d got=0 want=1", r);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'(100 + i);
      tick();
      total++;
      if (count !== 7'd45 || rd_data !== 8'(i)) begin
        bad++;
        $display("FAIL b2b i=%0d got=%0d/%h want=45/%h",
                 i, count, rd_data, 8'(i));
      end
    end
    wr_en = 1'b0;
    for (int i = 20; i < 65; i++) begin
      rd_en = 1'b1;
      tick();
      total++;
      if (rd_data !== ((i < 45) ? 8'(i) : 8'(i + 55))) begin
        bad++;
        $display("FAIL b2b_tail i=%0d got=%h", i, rd_data);
      end
    end
    rd_en = 1'b0;
    total++;
    if (count !== 7'd0 || almost_empty !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end got=%0d/%b want=0/1", count, almost_empty);
    end
  endtask

  task automatic test_simul_edges;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    rd_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++;
    if (count !== 7'd89 || rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL sim_full got=%0d/%b/%h want=89/1/00",
               count, rd_valid, rd_data);
    end
    total++;
    if (overflow !== ERR) begin
      bad++;
      $display("FAIL sim_full_ovf got=%b want=%b", overflow, ERR);
    end
    for (int i = 1; i < 90; i++) begin
      tick();
      total++;
      if (rd_data !== 8'(i)) begin
        bad++;
        $display("FAIL sim_full_drain i=%0d got=%h", i, rd_data);
      end
    end
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    total++;
    if (count !== 7'd1 || rd_valid !== 1'b0 || rd_data !== 8'h59) begin
      bad++;
      $display("FAIL sim_empty got=%0d/%b/%h want=1/0/59",
               count, rd_valid, rd_data);
    end
    total++;
    if (underflow !== ERR) begin
      bad++;
      $display("FAIL sim_empty_unf got=%b want=%b", underflow, ERR);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 8'h77 || empty !== 1'b1) begin
      bad++;
      $display("FAIL sim_empty_rd got=%h/%b want=77/1", rd_data, empty);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 31; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i + 16);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    total++;
    if (count !== 7'd30 || rd_data !== 8'h10) begin
      bad++;
      $display("FAIL mid_pre got=%0d/%h want=30/10", count, rd_data);
    end
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    total++;
    if (count !== 7'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst got=%0d/%b/%h want=0/1/00",
               count, empty, rd_data);
    end
    total++;
    if ({overflow, underflow, rd_valid} !== 3'b000) begin
      bad++;
      $display("FAIL mid_err got=%b want=000",
               {overflow, underflow, rd_valid});
    end
    tick();
    total++;
    if (count !== 7'd0) begin
      bad++;
      $display("FAIL mid_ignored got=%0d want=0", count);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_simul_edges();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO buffer. Generalises the team's dual-port byte RAM by adding:
  - configurable data width and depth (power-of-2 not required);
  - internal wrap-around pointers;
  - occupancy count, full/empty and almost-full/almost-empty flags.
- Used for buffering between same-clock producer and consumer blocks (UART/SPI data paths, pipeline decoupling).

Parameters:
- DATA_W, 8, data word width in bits
- DEPTH, 90, number of storage words; any value >= 2
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL
- AE_LVL, 2, almost_empty asserts when count <= AE_LVL

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  high for one cycle when rd_data was updated by an accepted read
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LVL
- almost_empty  out  1  count <= AE_LVL
- overflow  out  1  sticky error, write attempted while full (feature-gated)
- underflow  out  1  sticky error, read attempted while empty (feature-gated)

Behaviour:
- Reset (rst high at posedge):
  - wr_ptr = 0, rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_LVL > 0).
  - Storage array is not reset.
- Reset mid-operation discards all contents; any wr_en/rd_en in the reset cycle is ignored.
- Write acceptance: wr_acc = wr_en && !full.
  - On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr advances.
- Read acceptance: rd_acc = rd_en && !empty.
  - On rd_acc: rd_data <= mem[rd_ptr] (1-cycle latency); rd_ptr advances; rd_valid = 1 next cycle.
  - Otherwise rd_data holds its value and rd_valid = 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits. Increment is ptr == DEPTH-1 ? 0 : ptr+1. No power-of-2 aliasing.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags are decoded combinationally from the registered count. They are valid in the cycle after the causing edge.
- Simultaneous events:
  - Both requests, 0 < count < DEPTH: both accepted, count unchanged.
  - Both requests, full: read accepted, write rejected, count -> DEPTH-1.
  - Both requests, empty: write accepted, read rejected (no bypass), rd_data unchanged, count -> 1.
- Read and write of the same address cannot collide: that requires empty or full, and one side is then blocked.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- Defined:
  - overflow sets when wr_en && full; underflow sets when rd_en && empty.
  - Both flags are sticky until rst.
  - Same-cycle simultaneous cases above that reject one side also set the corresponding flag.
- Undefined: overflow and underflow are tied to 0 and no error logic is synthesised. The ports remain present.

Decomposition:
- Package sync_fifo_pkg:
  - function for pointer width (clog2 with minimum 1);
  - function for count width;
  - localparams for default AF/AE offsets.
- Sub-module sync_fifo_ram: DEPTH x DATA_W storage with a registered read port.
  - Write port: we, waddr, wdata. Read port: re, raddr, rdata.
  - No reset on the array; rdata is reset to 0.
- Top level holds pointers, count, flags and error logic.

Test Plan:
- Reset, then 90 writes (values 0x00..0x59), no reads -> count = 90, full = 1 after the last write, almost_full asserted from count 88; 91st write rejected, overflow = 1 (ERR_EN).
- From full, 90 reads -> rd_data sequence 0x00..0x59 with rd_valid each cycle after the request, empty = 1 at the end; extra read gives underflow = 1 and rd_data stays 0x59.
- Wrap-around: write 60, read 60, write 60, read 60 -> pointers wrap 89 -> 0, data order preserved, never full.
- Simultaneous wr_en + rd_en at count 45 for 20 cycles -> count stays 45, output order correct.
- Simultaneous requests at full -> count 89, write dropped; at empty -> count 1, rd_valid = 0.
- Assert rst while count = 30 -> next cycle count = 0, empty = 1, rd_data = 0, error flags cleared.
